// File: rtl/matmul_lane_engine.sv
// Multi-lane fixed-point matrix multiplier over synchronous-read A/B/C buffers.
// Each pass streams one A row against LANES B columns and writes one packed C word.
module matmul_lane_engine #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int LANES     = 4,
  parameter int MAX_M     = 16,
  parameter int MAX_K     = 16,
  parameter int MAX_N     = 16,
  parameter int RD_LAT    = 1,
  parameter int ACC_W     = 2*DATA_W + $clog2(MAX_K),
  localparam int MW       = $clog2(MAX_M) + 1,
  localparam int KW       = $clog2(MAX_K) + 1,
  localparam int NW       = $clog2(MAX_N) + 1,
  localparam int NGMAX    = (MAX_N + LANES - 1) / LANES,
  localparam int AAW      = $clog2(MAX_M*MAX_K),
  localparam int BAW      = $clog2(MAX_K*NGMAX),
  localparam int CAW      = $clog2(MAX_M*NGMAX)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [MW-1:0]             M_val,
  input  logic [KW-1:0]             K_val,
  input  logic [NW-1:0]             N_val,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      a_en,
  output logic [AAW-1:0]            a_addr,
  input  logic [DATA_W-1:0]         a_rdata,
  output logic                      b_en,
  output logic [BAW-1:0]            b_addr,
  input  logic [LANES*DATA_W-1:0]   b_rdata,
  output logic                      c_we,
  output logic [LANES-1:0]          c_mask,
  output logic [CAW-1:0]            c_addr,
  output logic [LANES*DATA_W-1:0]   c_wdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [1:0]      state;
  logic [MW-1:0]   m_r, row;
  logic [KW-1:0]   k_r, kc;
  logic [NW-1:0]   n_r, ng_r, grp;
  logic            relu_r;
  logic [RD_LAT-1:0] vld_p0;
  logic            dims_ok, accept, clear_acc;
  logic [NW-1:0]   ng_calc;

  logic signed [DATA_W-1:0]   a_s;
  logic signed [DATA_W-1:0]   b_s    [LANES];
  logic signed [2*DATA_W-1:0] prod_p1[LANES];
  logic signed [ACC_W-1:0]    acc_p1 [LANES];

  function automatic logic signed [ACC_W-1:0] relu_fn(input logic signed [ACC_W-1:0] v,
                                                      input logic en);
    return (en && v < 0) ? '0 : v;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI) return SAT_HI[DATA_W-1:0];
    if (v < SAT_LO) return SAT_LO[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  assign dims_ok = (M_val != '0) && (M_val <= MW'(MAX_M)) &&
                   (K_val != '0) && (K_val <= KW'(MAX_K)) &&
                   (N_val != '0) && (N_val <= NW'(MAX_N));
  assign accept    = (state == S_IDLE) && start && dims_ok;
  assign clear_acc = accept || (state == S_WRITE);
  assign ng_calc   = NW'((N_val + NW'(LANES - 1)) / NW'(LANES));

  // Control: job sequencing, read-valid tracking and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      m_r    <= '0;
      k_r    <= '0;
      n_r    <= '0;
      ng_r   <= '0;
      relu_r <= 1'b0;
      row    <= '0;
      grp    <= '0;
      kc     <= '0;
      vld_p0 <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      vld_p0 <= (vld_p0 << 1) | RD_LAT'(state == S_ISSUE);
      case (state)
        S_IDLE: begin
          if (start && dims_ok) begin
            m_r    <= M_val;
            k_r    <= K_val;
            n_r    <= N_val;
            ng_r   <= ng_calc;
            relu_r <= relu_en;
            row    <= '0;
            grp    <= '0;
            kc     <= '0;
            busy   <= 1'b1;
            state  <= S_ISSUE;
          end else if (start) begin
            done <= 1'b1;
            err  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (kc == k_r - KW'(1)) begin
            kc    <= '0;
            state <= S_DRAIN;
          end else begin
            kc <= kc + KW'(1);
          end
        end
        S_DRAIN: begin
          // The last read lands in the final drain cycle, so a fixed count suffices
          if (kc == KW'(RD_LAT - 1)) begin
            kc    <= '0;
            state <= S_WRITE;
          end else begin
            kc <= kc + KW'(1);
          end
        end
        default: begin
          kc <= '0;
          if (grp != ng_r - NW'(1)) begin
            grp   <= grp + NW'(1);
            state <= S_ISSUE;
          end else if (row != m_r - MW'(1)) begin
            row   <= row + MW'(1);
            grp   <= '0;
            state <= S_ISSUE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Stage p1: per-lane products of the returning A element and B word
  always_comb begin
    a_s = a_rdata;
    for (int l = 0; l < LANES; l++) begin
      b_s[l]     = b_rdata[l*DATA_W +: DATA_W];
      prod_p1[l] = a_s * b_s[l];
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (clear_acc)
        acc_p1[l] <= '0;
      else if (vld_p0[RD_LAT-1])
        acc_p1[l] <= acc_p1[l] + ACC_W'(prod_p1[l]);
    end
  end

  // Output stage: buffer addressing and post-processed write word
  always_comb begin
    a_en    = (state == S_ISSUE);
    b_en    = (state == S_ISSUE);
    c_we    = (state == S_WRITE);
    a_addr  = '0;
    b_addr  = '0;
    c_addr  = '0;
    c_mask  = '0;
    c_wdata = '0;
    if (state == S_ISSUE) begin
      a_addr = AAW'(int'(row) * int'(k_r) + int'(kc));
      b_addr = BAW'(int'(kc) * int'(ng_r) + int'(grp));
    end
    if (state == S_WRITE) begin
      c_addr = CAW'(int'(row) * int'(ng_r) + int'(grp));
      for (int l = 0; l < LANES; l++) begin
        if (int'(grp) * LANES + l < int'(n_r)) begin
          c_mask[l] = 1'b1;
          c_wdata[l*DATA_W +: DATA_W] = sat_fn(relu_fn(acc_p1[l] >>> FRAC_BITS, relu_r));
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_lane_engine.sv
// Scoreboard bench for matmul_lane_engine: expected C writes come from a plain
// arithmetic matrix model; a monitor compares every C write as the DUT issues it.
module tb_matmul_lane_engine;
  localparam int DATA_W = 16, FRAC_BITS = 8, LANES = 4;
  localparam int MAX_M = 16, MAX_K = 16, MAX_N = 16, RD_LAT = 3;
  localparam int DW = 5, NGMAX = 4, AAW = 8, BAW = 6, CAW = 6;
  localparam int WW = LANES*DATA_W;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu_en = 1'b0;
  logic [DW-1:0] M_val = '0, K_val = '0, N_val = '0;
  logic busy, done, err, a_en, b_en, c_we;
  logic [AAW-1:0] a_addr;
  logic [BAW-1:0] b_addr;
  logic [CAW-1:0] c_addr;
  logic [LANES-1:0] c_mask;
  logic [DATA_W-1:0] a_rdata;
  logic [WW-1:0] b_rdata, c_wdata;

  int errors = 0, checks = 0, a_en_cnt = 0, c_we_cnt = 0;

  matmul_lane_engine #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .LANES(LANES),
    .MAX_M(MAX_M), .MAX_K(MAX_K), .MAX_N(MAX_N), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M_val(M_val), .K_val(K_val),
    .N_val(N_val), .relu_en(relu_en), .busy(busy), .done(done), .err(err),
    .a_en(a_en), .a_addr(a_addr), .a_rdata(a_rdata), .b_en(b_en),
    .b_addr(b_addr), .b_rdata(b_rdata), .c_we(c_we), .c_mask(c_mask),
    .c_addr(c_addr), .c_wdata(c_wdata));

  always #5 clk = ~clk;

  // Buffer models: RD_LAT-deep synchronous reads, garbage when not enabled
  logic [DATA_W-1:0] a_mem [MAX_M*MAX_K];
  logic [WW-1:0]     b_mem [MAX_K*NGMAX];
  logic [WW-1:0]     c_mem [MAX_M*NGMAX];
  logic [DATA_W-1:0] a_pipe [RD_LAT];
  logic [WW-1:0]     b_pipe [RD_LAT];
  int am [MAX_M][MAX_K];
  int bm [MAX_K][MAX_N];

  always @(posedge clk) begin
    a_pipe[0] <= a_en ? a_mem[a_addr] : DATA_W'($urandom);
    b_pipe[0] <= b_en ? b_mem[b_addr] : {$urandom, $urandom};
    for (int i = 1; i < RD_LAT; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
    if (c_we)
      for (int l = 0; l < LANES; l++)
        if (c_mask[l]) c_mem[c_addr][l*DATA_W +: DATA_W] <= c_wdata[l*DATA_W +: DATA_W];
  end
  assign a_rdata = a_pipe[RD_LAT-1];
  assign b_rdata = b_pipe[RD_LAT-1];

  typedef struct {
    logic [CAW-1:0]   addr;
    logic [LANES-1:0] mask;
    logic [WW-1:0]    data;
  } wr_t;
  wr_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_en) a_en_cnt++;
    if (rst_n && c_we) begin
      c_we_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual_addr=%0d required=no write", c_addr);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("c_addr", c_addr, e.addr);
        check("c_mask", c_mask, e.mask);
        check("c_wdata", c_wdata, e.data);
      end
    end
  end

  // C[r][c] = sat(relu(sum_k A[r][k]*B[k][c] >> FRAC_BITS)), plain arithmetic
  function automatic logic [DATA_W-1:0] ref_elem(int r, int c, int kk, bit relu);
    longint s = 0;
    longint hi = (longint'(1) << (DATA_W-1)) - 1;
    longint lo = -(longint'(1) << (DATA_W-1));
    for (int k = 0; k < kk; k++) s += longint'(am[r][k]) * longint'(bm[k][c]);
    s = s >>> FRAC_BITS;
    if (relu && s < 0) s = 0;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return DATA_W'(s);
  endfunction

  task automatic fill_random(int mag);
    for (int i = 0; i < MAX_M; i++)
      for (int j = 0; j < MAX_K; j++) am[i][j] = int'($urandom_range(2*mag-1)) - mag;
    for (int i = 0; i < MAX_K; i++)
      for (int j = 0; j < MAX_N; j++) bm[i][j] = int'($urandom_range(2*mag-1)) - mag;
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin am[i][j] = 0; bm[i][j] = 0; end
  endtask

  task automatic load_and_expect(int m, int kk, int n, bit relu);
    int ng;
    logic [WW-1:0] w;
    wr_t e;
    ng = (n + LANES - 1) / LANES;
    for (int r = 0; r < m; r++)
      for (int k = 0; k < kk; k++) a_mem[r*kk + k] = DATA_W'(am[r][k]);
    for (int k = 0; k < kk; k++)
      for (int g = 0; g < ng; g++) begin
        w = '0;
        for (int l = 0; l < LANES; l++) w[l*DATA_W +: DATA_W] = DATA_W'(bm[k][g*LANES + l]);
        b_mem[k*ng + g] = w;
      end
    for (int r = 0; r < m; r++)
      for (int g = 0; g < ng; g++) begin
        e.addr = CAW'(r*ng + g);
        e.mask = '0;
        e.data = '0;
        for (int l = 0; l < LANES; l++)
          if (g*LANES + l < n) begin
            e.mask[l] = 1'b1;
            e.data[l*DATA_W +: DATA_W] = ref_elem(r, g*LANES + l, kk, relu);
          end
        sb_q.push_back(e);
      end
  endtask

  task automatic run_job(int m, int kk, int n, bit relu, bit expect_err, bit poke);
    int cyc, exp_cyc, ng, a0, w0;
    bit got;
    ng = (n + LANES - 1) / LANES;
    if (!expect_err) load_and_expect(m, kk, n, relu);
    a0 = a_en_cnt;
    w0 = c_we_cnt;
    @(posedge clk); #1;
    start = 1'b1; M_val = DW'(m); K_val = DW'(kk); N_val = DW'(n); relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 2;
    exp_cyc = expect_err ? 2 : 2 + m*ng*(kk + RD_LAT + 1);
    if (!expect_err) check("busy_after_start", busy, 1);
    got = 1'b0;
    while (cyc < exp_cyc + 50) begin
      if (done) begin got = 1'b1; break; end
      if (poke && cyc == 4) begin
        start = 1'b1; M_val = 5'd1; K_val = 5'd1; N_val = 5'd1; relu_en = ~relu;
      end
      if (poke && cyc == 5) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", got, 1);
    check("done_cycle", cyc, exp_cyc);
    check("err_with_done", err, expect_err);
    @(posedge clk); #1;
    check("done_one_cycle", {done, err, busy}, 0);
    if (expect_err) begin
      check("err_no_a_reads", a_en_cnt - a0, 0);
      check("err_no_c_writes", c_we_cnt - w0, 0);
    end else begin
      check("writes_per_job", c_we_cnt - w0, m*ng);
      check("queue_drained", sb_q.size(), 0);
    end
    sb_q.delete();
  endtask

  initial begin
    int w0, waited;
    bit hit, saw_done;
    clear_mats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, err, a_en, b_en, c_we, c_mask}, 0);
    check("reset_addr", {a_addr, b_addr, c_addr}, 0);
    check("reset_wdata", c_wdata, 0);
    rst_n = 1'b1;

    // Identity A times B = B (1.0 == 256)
    am[0][0] = 256; am[1][1] = 256;
    bm[0][0] = 256; bm[0][1] = 512; bm[1][0] = 768; bm[1][1] = 1024;
    run_job(2, 2, 2, 1'b0, 1'b0, 1'b0);
    check("ident_c00", c_mem[0][15:0], 256);
    check("ident_c01", c_mem[0][31:16], 512);
    check("ident_c10", c_mem[1][15:0], 768);
    check("ident_c11", c_mem[1][31:16], 1024);

    // Partial last group: N=6 gives masks 1111 then 0011
    fill_random(512);
    run_job(2, 3, 6, 1'b0, 1'b0, 1'b0);

    // ReLU of -5.0, raw -5.0, positive and negative saturation
    clear_mats();
    am[0][0] = 256; bm[0][0] = -1280;
    c_mem[0] = '1;
    run_job(1, 1, 1, 1'b1, 1'b0, 1'b0);
    check("relu_neg_zero", c_mem[0][15:0], 0);
    run_job(1, 1, 1, 1'b0, 1'b0, 1'b0);
    check("neg_no_relu", c_mem[0][15:0], 16'hFB00);
    am[0][0] = 2560; bm[0][0] = 5120;
    run_job(1, 1, 1, 1'b0, 1'b0, 1'b0);
    check("sat_pos", c_mem[0][15:0], 16'h7FFF);
    bm[0][0] = -5120;
    run_job(1, 1, 1, 1'b0, 1'b0, 1'b0);
    check("sat_neg", c_mem[0][15:0], 16'h8000);

    // Illegal dimensions
    run_job(2, 0, 2, 1'b0, 1'b1, 1'b0);
    run_job(17, 2, 2, 1'b0, 1'b1, 1'b0);
    run_job(2, 2, 17, 1'b0, 1'b1, 1'b0);

    // Randomized jobs, some with a start/dim change while busy
    for (int t = 0; t < 8; t++) begin
      fill_random(($urandom_range(1) == 1) ? 32768 : 1024);
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(2, 16)),
              int'($urandom_range(1, 16)), 1'($urandom_range(1)), 1'b0, t[0]);
    end
    fill_random(1024);
    run_job(16, 1, 16, 1'b1, 1'b0, 1'b0);

    // Reset asserted during the row-1 issue phase
    fill_random(1024);
    load_and_expect(3, 4, 4, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; M_val = 5'd3; K_val = 5'd4; N_val = 5'd4; relu_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    waited = 0;
    while (waited < 200) begin
      if (a_en && a_addr == 8'd4) begin hit = 1'b1; break; end
      @(posedge clk); #1;
      waited++;
    end
    check("abort_reached_row1", hit, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl_zero", {busy, done, err, a_en, b_en, c_we, c_mask}, 0);
    check("abort_addr_zero", {a_addr, b_addr, c_addr}, 0);
    check("abort_wdata_zero", c_wdata, 0);
    sb_q.delete();
    w0 = c_we_cnt;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done_or_busy", saw_done, 0);
    check("abort_no_writes", c_we_cnt - w0, 0);
    run_job(3, 4, 4, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
